// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract sequencer driving one external 1-bit full-adder slice, LSB first.
// Latency: start accepted at edge N, result/flags and done_o presented after edge N+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: none; start_i is only honoured in IDLE, requests while busy are dropped, not queued.
module serial_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_cin_o,
  input  logic             fa_sum_i,
  input  logic             fa_cout_i
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Sum bits collected so far; the final (MSB) bit arrives straight from the
  // slice on the last RUN edge, so only WIDTH-1 bits need storing.
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             fa_a_q, fa_a_d;
  logic             fa_b_q, fa_b_d;
  logic             fa_cin_q, fa_cin_d;
  logic [WIDTH-1:0] full_sum;

  // Next-state and datapath: load operands on start, shift one bit per RUN edge, latch results on the last bit.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    s_sr_d   = s_sr_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    full_sum = {fa_sum_i, s_sr_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          a_sr_d  = a_i;
          // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
          b_sr_d  = op_i ? ~b_i : b_i;
          cy_d    = op_i;
          cnt_d   = '0;
          s_sr_d  = '0;
        end
      end
      S_RUN: begin
        s_sr_d = (WIDTH-1)'(full_sum >> 1);
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cy_d   = fa_cout_i;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = full_sum;
          carry_d  = fa_cout_i;
          // cy_q is the carry into the MSB during the last bit.
          ovf_d    = cy_q ^ fa_cout_i;
          zero_d   = (full_sum == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Slice drive is computed from next state so it comes straight off flops.
    fa_a_d   = (state_d == S_RUN) & a_sr_d[0];
    fa_b_d   = (state_d == S_RUN) & b_sr_d[0];
    fa_cin_d = (state_d == S_RUN) & cy_d;
  end

  // State and datapath registers, cleared asynchronously so a reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      s_sr_q   <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      fa_a_q   <= 1'b0;
      fa_b_q   <= 1'b0;
      fa_cin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      s_sr_q   <= s_sr_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      fa_a_q   <= fa_a_d;
      fa_b_q   <= fa_b_d;
      fa_cin_q <= fa_cin_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = zero_q;
  assign fa_a_o   = fa_a_q;
  assign fa_b_o   = fa_b_q;
  assign fa_cin_o = fa_cin_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: external full-adder slice model, scoreboard of expected results, per-bit slice checks.
// Latency: expects done WIDTH+1 edges after start, single-cycle pulse.
// Backpressure: exercises dropped starts while busy and a continuously held start.
module tb_serial_alu_seq;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, op_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, done_o, carry_o, ovf_o, zero_o;
  logic [W-1:0] result_o;
  logic         fa_a_o, fa_b_o, fa_cin_o, fa_sum, fa_cout;
  logic         ha_s, ha_c;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_r = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // External slice: two half adders plus an OR.
  assign ha_s    = fa_a_o ^ fa_b_o;
  assign ha_c    = fa_a_o & fa_b_o;
  assign fa_sum  = ha_s ^ fa_cin_o;
  assign fa_cout = ha_c | (ha_s & fa_cin_o);

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .carry_o(carry_o), .ovf_o(ovf_o), .zero_o(zero_o),
    .fa_a_o(fa_a_o), .fa_b_o(fa_b_o), .fa_cin_o(fa_cin_o),
    .fa_sum_i(fa_sum), .fa_cout_i(fa_cout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic exp_t model(input int a, input int b, input bit op);
    exp_t e;
    int sa, sb, t, u;
    sa  = (a >= MOD / 2) ? a - MOD : a;
    sb  = (b >= MOD / 2) ? b - MOD : b;
    t   = op ? sa - sb : sa + sb;
    u   = op ? a - b : a + b;
    u   = ((u % MOD) + MOD) % MOD;
    e.r = u[W-1:0];
    e.c = op ? (a >= b) : (a + b >= MOD);
    e.v = (t < -(MOD / 2)) || (t > MOD / 2 - 1);
    e.z = (u == 0);
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      chk("done_single_cycle", int'(prev_done), 0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=done with empty scoreboard, required=no done");
      end else begin
        e = sb_q.pop_front();
        chk("result", int'(result_o), int'(e.r));
        chk("carry", int'(carry_o), int'(e.c));
        chk("ovf", int'(ovf_o), int'(e.v));
        chk("zero", int'(zero_o), int'(e.z));
      end
    end
    prev_done = (rst_n === 1'b1) ? done_o : 1'b0;
  end

  // One operation with per-bit slice checks; inj >= 0 pulses a stray start in that RUN cycle.
  task automatic do_op(input int a, input int b, input bit op, input int inj);
    exp_t e;
    int lowa, lowb, ecin;
    e = model(a, b, op);
    @(negedge clk);
    a_i = W'(a); b_i = W'(b); op_i = op; start_i = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); op_i = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      lowa = a % (1 << i);
      lowb = b % (1 << i);
      if (i == 0) ecin = int'(op);
      else ecin = op ? int'(lowa >= lowb) : int'(lowa + lowb >= (1 << i));
      chk("fa_a", int'(fa_a_o), (a >> i) & 1);
      chk("fa_b", int'(fa_b_o), ((b >> i) & 1) ^ int'(op));
      chk("fa_cin", int'(fa_cin_o), ecin);
      chk("busy_run", int'(busy_o), 1);
      chk("done_run", int'(done_o), 0);
      chk("result_stable_run", int'(result_o), last_r);
      if (i == inj) begin
        start_i = 1'b1; a_i = 1; b_i = 1; op_i = 1'b0;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("busy_done", int'(busy_o), 1);
    chk("done_pulse", int'(done_o), 1);
    chk("fa_idle", int'({fa_a_o, fa_b_o, fa_cin_o}), 0);
    last_r = int'(e.r);
    @(negedge clk);
    chk("busy_after", int'(busy_o), 0);
    chk("done_after", int'(done_o), 0);
    chk("result_held", int'(result_o), last_r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_prev;
    rst_n = 1'b0; start_i = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0;
    #12;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_result", int'(result_o), 0);
    chk("rst_flags", int'({carry_o, ovf_o, zero_o}), 0);
    chk("rst_fa", int'({fa_a_o, fa_b_o, fa_cin_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3, 5, 1'b0, -1);   // 8: ovf
    do_op(9, 7, 1'b0, -1);   // 0: carry, zero
    do_op(5, 3, 1'b1, -1);   // 2
    do_op(3, 5, 1'b1, -1);   // 14: borrow
    do_op(8, 1, 1'b1, -1);   // 7: ovf
    do_op(2, 2, 1'b0, 1);    // stray start ignored
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_extra_done", int'(done_o), 0);
      chk("no_extra_busy", int'(busy_o), 0);
      chk("result_still", int'(result_o), 4);
    end

    // Start held high: back-to-back ops every WIDTH+2 cycles.
    @(negedge clk);
    a_i = 1; b_i = 2; op_i = 1'b0; start_i = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back(model(1, 2, 1'b0));
    t_prev = -1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n = 0;
      while (done_o !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (done_o !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL held_start_timeout: actual=no done in 20 cycles required=done");
      end else if (k > 0) begin
        chk("held_spacing", cyc - t_prev, W + 2);
      end
      t_prev = cyc;
      if (k == 2) start_i = 1'b0;
    end
    last_r = 3;
    @(negedge clk);
    chk("held_stop_busy", int'(busy_o), 0);

    // Asynchronous reset in the middle of RUN.
    do_op(5, 3, 1'b1, -1);
    @(negedge clk);
    a_i = 6; b_i = 5; op_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_result", int'(result_o), 0);
    chk("abort_flags", int'({carry_o, ovf_o, zero_o}), 0);
    chk("abort_fa", int'({fa_a_o, fa_b_o, fa_cin_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_r = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done_o), 0);
    end
    do_op(6, 5, 1'b0, -1);

    for (int k = 0; k < 24; k++)
      do_op(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)), 1'($urandom), -1);

    @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
